// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, flag bit positions and stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational result and {Z,N,C,V} flags for single-cycle ops.
//            Shift opcodes pass operand A through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [WIDTH-1:0] w_xor;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_c;
  logic             w_v;

  xor_unit #(.WIDTH(WIDTH)) u_xor (
    .i_a (i_a),
    .i_b (i_b),
    .o_y (w_xor)
  );

  // The extra top bit of w_diff is the borrow, set exactly when a < b unsigned.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_result = i_a;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_op)
      OP_AND: w_result = i_a & i_b;
      OP_OR:  w_result = i_a | i_b;
      OP_XOR: w_result = w_xor;
      OP_ADD: begin
        {w_c, w_result} = w_sum;
        w_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        {w_c, w_result} = w_diff;
        w_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_NOT: w_result = ~i_a;
      default: w_result = i_a;
    endcase
  end

  always_comb begin
    o_result        = w_result;
    o_flags         = 4'b0000;
    o_flags[FLAG_Z] = (w_result == '0);
    o_flags[FLAG_N] = w_result[WIDTH-1];
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule : alu_core

`default_nettype wire

// File: rtl/xor_unit.sv
// ============================================================================
// Module   : xor_unit
// Purpose  : Bitwise XOR of two WIDTH-bit operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_a ^ i_b;

endmodule : xor_unit

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Registered execute stage with valid/ready handshake; iterative
//            shifts are built only when ALU_STAGE_SHIFT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             busy
);

  logic [WIDTH-1:0] w_core_result;
  logic [3:0]       w_core_flags;
  logic             w_idle;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_result;
  logic [3:0]       w_load_flags;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  assign in_ready = !rst && w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_STAGE_SHIFT_EN
  localparam int c_CNT_W = $clog2(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dir_right;

  logic               w_is_shift;
  logic               w_shift_start;
  logic               w_shift_done;
  logic [WIDTH-1:0]   w_work_next;
  logic               w_carry_next;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_is_shift    = (in_op == OP_SHL) || (in_op == OP_SHR);
  assign w_shift_start = w_accept && w_is_shift && (in_b[c_CNT_W-1:0] != '0);
  assign w_work_next   = r_dir_right ? {1'b0, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
  assign w_carry_next  = r_dir_right ? r_work[0] : r_work[WIDTH-1];
  assign w_shift_done  = (r_state == ST_SHIFT) && (r_cnt == c_CNT_W'(1));

  // Count-0 shifts take the direct path: the core passes A through with C=0.
  assign w_load        = (w_accept && !w_shift_start) || w_shift_done;
  assign w_load_result = w_shift_done ? w_work_next : w_core_result;
  assign w_load_flags  = w_shift_done ?
                         {(w_work_next == '0), w_work_next[WIDTH-1], w_carry_next, 1'b0} :
                         w_core_flags;
  assign busy          = (r_state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_shift_start) begin
            r_state     <= ST_SHIFT;
            r_work      <= in_a;
            r_cnt       <= in_b[c_CNT_W-1:0];
            r_dir_right <= (in_op == OP_SHR);
          end
        end
        ST_SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt - c_CNT_W'(1);
          if (w_shift_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign w_idle        = 1'b1;
  assign w_load        = w_accept;
  assign w_load_result = w_core_result;
  assign w_load_flags  = w_core_flags;
  assign busy          = 1'b0;
`endif

  // A load only happens when the register is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_result;
      r_flags     <= w_load_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;

endmodule : alu_exec_stage

`default_nettype wire
